// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the instruction-cache geometry, frame layout and
// controller states. The structs describe the default cache geometry.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_FRAMES = 16;
  localparam int ICACHE_IDX_W  = $clog2(ICACHE_FRAMES);
  localparam int ICACHE_TAG_W  = 30 - ICACHE_IDX_W;

  // One cache frame: a single instruction word with its tag and valid bit.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  // Byte address split into the fields the cache looks at.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frames.sv
// Frame storage for the direct-mapped instruction cache: one synchronous
// write port (used by the fill) and one combinational read port (used by
// the lookup). Reset clears every frame, so it is built from flops.
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int FRAMES = ICACHE_FRAMES,
  parameter int IDX_W  = $clog2(FRAMES),
  parameter int TAG_W  = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             sRST,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  word_t            wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output word_t            rd_data
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } frame_t;

  frame_t frames [FRAMES];

  generate
    for (genvar gi = 0; gi < FRAMES; gi++) begin : g_frame
      frame_t frame_reg;

      // Clear on reset; otherwise load this frame when the fill targets it.
      always_ff @(posedge CLK) begin
        if (sRST) begin
          frame_reg <= '0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          frame_reg.valid <= 1'b1;
          frame_reg.tag   <= wr_tag;
          frame_reg.data  <= wr_data;
        end
      end

      assign frames[gi] = frame_reg;
    end
  endgenerate

  assign rd_valid = frames[rd_idx].valid;
  assign rd_tag   = frames[rd_idx].tag;
  assign rd_data  = frames[rd_idx].data;

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache. Hits are answered in the same
// cycle from the frame store; a miss latches the word address, reads one
// word from memory, fills the frame, and hits on the cycle after the fill.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int FRAMES = ICACHE_FRAMES,
  parameter int IDX_W  = $clog2(FRAMES),
  parameter int TAG_W  = 30 - IDX_W
) (
  input  logic  CLK,
  input  logic  sRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  icache_state_t state_reg;
  logic [29:0]   miss_word_reg;  // word address of the outstanding miss
  logic          iren_reg;
  word_t         hit_count_reg;
  word_t         miss_count_reg;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             frame_valid;
  logic [TAG_W-1:0] frame_tag;
  word_t            frame_data;
  logic             hit;
  logic             fill_en;
  logic             unused_bytoff;

  assign req_idx       = imemaddr[IDX_W+1:2];
  assign req_tag       = imemaddr[31:IDX_W+2];
  assign unused_bytoff = ^imemaddr[1:0];

  // The fill lands on the FETCH cycle where memory stops waiting.
  assign fill_en = (state_reg == FETCH) && !iwait;

  icache_frames #(
    .FRAMES (FRAMES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_frames (
    .CLK      (CLK),
    .sRST     (sRST),
    .wr_en    (fill_en),
    .wr_idx   (miss_word_reg[IDX_W-1:0]),
    .wr_tag   (miss_word_reg[29:IDX_W]),
    .wr_data  (iload),
    .rd_idx   (req_idx),
    .rd_valid (frame_valid),
    .rd_tag   (frame_tag),
    .rd_data  (frame_data)
  );

  // No forwarding from the fill: lookups only resolve while idle.
  assign hit = imemREN && frame_valid && (frame_tag == req_tag) && (state_reg == IDLE);

  assign ihit       = hit;
  assign imemload   = frame_data;
  assign iREN       = iren_reg;
  assign iaddr      = iren_reg ? {miss_word_reg, 2'b00} : '0;
  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

  // Miss-handling FSM with the memory request flag and performance counters.
  always_ff @(posedge CLK) begin
    if (sRST) begin
      state_reg      <= IDLE;
      miss_word_reg  <= '0;
      iren_reg       <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (hit) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      case (state_reg)
        IDLE: begin
          if (imemREN && !hit) begin
            miss_word_reg  <= imemaddr[31:2];
            miss_count_reg <= miss_count_reg + 32'd1;
            iren_reg       <= 1'b1;
            state_reg      <= FETCH;
          end
        end
        FETCH: begin
          // A redirect does not cancel the transfer; the fill always completes.
          if (!iwait) begin
            iren_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          iren_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios followed by random traffic,
// every cycle checked against a frame-level model of the cache.
module tb_icache_direct;
  import cpu_types_pkg::*;

  localparam int NF = 16;

  logic  CLK = 1'b0;
  logic  sRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  word_t hit_count;
  word_t miss_count;

  always #5 CLK = ~CLK;

  icache_direct dut (
    .CLK        (CLK),
    .sRST       (sRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-frame contents plus an optional outstanding miss.
  bit          m_valid [NF];
  int unsigned m_tag   [NF];
  word_t       m_data  [NF];
  bit          m_busy;
  word_t       m_addr;
  word_t       m_hits;
  word_t       m_misses;

  // Outputs observed during the most recent cycle.
  logic  o_ihit, o_iren;
  word_t o_load, o_iaddr, o_hc, o_mc;

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_data[i]  = '0;
    end
    m_busy   = 1'b0;
    m_addr   = '0;
    m_hits   = '0;
    m_misses = '0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input bit ren, input word_t addr, input bit wt,
                       input word_t load, input bit rst);
    int          idx;
    int unsigned tg;
    int          fidx;
    bit          exp_hit;
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = load;
    sRST     = rst;
    idx      = int'((addr / 4) % NF);
    tg       = addr / (4 * NF);
    exp_hit  = !m_busy && ren && m_valid[idx] && (m_tag[idx] == tg);
    @(negedge CLK);
    o_ihit  = ihit;
    o_iren  = iREN;
    o_load  = imemload;
    o_iaddr = iaddr;
    o_hc    = hit_count;
    o_mc    = miss_count;
    check_eq("ihit", 32'(o_ihit), 32'(exp_hit));
    check_eq("imemload", o_load, m_data[idx]);
    check_eq("iREN", 32'(o_iren), 32'(m_busy));
    check_eq("iaddr", o_iaddr, m_busy ? m_addr : 32'h0);
    check_eq("hit_count", o_hc, m_hits);
    check_eq("miss_count", o_mc, m_misses);
    @(posedge CLK);
    if (rst) begin
      model_reset();
      $display("txn reset");
    end else begin
      if (exp_hit) m_hits++;
      if (m_busy) begin
        if (!wt) begin
          fidx          = int'((m_addr / 4) % NF);
          m_valid[fidx] = 1'b1;
          m_tag[fidx]   = m_addr / (4 * NF);
          m_data[fidx]  = load;
          m_busy        = 1'b0;
          $display("txn fill addr=%h data=%h", m_addr, load);
        end
      end else if (ren && !exp_hit) begin
        m_busy   = 1'b1;
        m_addr   = addr & 32'hFFFF_FFFC;
        m_misses++;
      end
    end
    #1;
  endtask

  initial begin
    int    iren_cycles;
    word_t pool [8];
    word_t a;

    sRST     = 1'b1;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    cycle(0, 32'h0, 1, 32'h0, 1);

    // 1: cold miss with three wait cycles
    iren_cycles = 0;
    cycle(1, 32'h40, 1, 32'h0, 0);
    iren_cycles += int'(o_iren);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h40, 1, 32'hDEADBEEF, 0);
      iren_cycles += int'(o_iren);
    end
    cycle(1, 32'h40, 0, 32'h8C220004, 0);
    iren_cycles += int'(o_iren);
    cycle(1, 32'h40, 1, 32'h0, 0);
    check_eq("t1_hit", 32'(o_ihit), 32'd1);
    check_eq("t1_load", o_load, 32'h8C220004);
    check_eq("t1_iren_cycles", 32'(iren_cycles), 32'd4);
    check_eq("t1_miss_count", o_mc, 32'd1);

    // 2: repeated hits
    for (int i = 0; i < 5; i++) begin
      cycle(1, 32'h40, 1, 32'h0, 0);
      check_eq("t2_hit", 32'(o_ihit), 32'd1);
      check_eq("t2_iren", 32'(o_iren), 32'd0);
    end
    cycle(0, 32'h40, 1, 32'h0, 0);
    check_eq("t2_hit_count", o_hc, 32'd6);

    // 3: conflict eviction on index 0
    cycle(1, 32'h80, 1, 32'h0, 0);
    check_eq("t3_miss80", 32'(o_ihit), 32'd0);
    cycle(1, 32'h80, 0, 32'h24010001, 0);
    cycle(1, 32'h80, 1, 32'h0, 0);
    check_eq("t3_load80", o_load, 32'h24010001);
    cycle(1, 32'h40, 1, 32'h0, 0);
    check_eq("t3_miss40", 32'(o_ihit), 32'd0);
    cycle(1, 32'h40, 0, 32'h8C220004, 0);
    check_eq("t3_miss_count", o_mc, 32'd3);
    cycle(1, 32'h40, 1, 32'h0, 0);

    // 4: redirect during the fill
    cycle(1, 32'h100, 1, 32'h0, 0);
    cycle(1, 32'h200, 1, 32'h0, 0);
    cycle(1, 32'h200, 0, 32'hAAAA5555, 0);
    cycle(1, 32'h200, 1, 32'h0, 0);
    check_eq("t4_miss200", 32'(o_ihit), 32'd0);
    check_eq("t4_frame100", o_load, 32'hAAAA5555);
    cycle(1, 32'h200, 0, 32'h13572468, 0);
    check_eq("t4_iaddr200", o_iaddr, 32'h200);
    cycle(1, 32'h200, 1, 32'h0, 0);
    cycle(1, 32'h100, 1, 32'h0, 0);
    cycle(1, 32'h100, 0, 32'hAAAA5555, 0);
    cycle(1, 32'h100, 1, 32'h0, 0);
    check_eq("t4_hit100", 32'(o_ihit), 32'd1);
    check_eq("t4_load100", o_load, 32'hAAAA5555);

    // 5: reset in the middle of a fill
    cycle(1, 32'h40, 1, 32'h0, 0);
    cycle(1, 32'h40, 0, 32'h8C220004, 0);
    cycle(1, 32'h40, 1, 32'h0, 0);
    cycle(1, 32'h44, 1, 32'h0, 0);
    cycle(1, 32'h44, 0, 32'h11112222, 1);
    cycle(1, 32'h40, 1, 32'h0, 0);
    check_eq("t5_iren", 32'(o_iren), 32'd0);
    check_eq("t5_hit", 32'(o_ihit), 32'd0);
    check_eq("t5_hc", o_hc, 32'd0);
    check_eq("t5_mc", o_mc, 32'd0);
    cycle(1, 32'h40, 0, 32'h8C220004, 0);
    check_eq("t5_refetch", o_iaddr, 32'h40);
    cycle(1, 32'h40, 1, 32'h0, 0);

    // 6: byte offset ignored
    cycle(1, 32'h43, 1, 32'h0, 0);
    check_eq("t6_hit", 32'(o_ihit), 32'd1);
    check_eq("t6_load", o_load, 32'h8C220004);
    cycle(0, 32'h0, 1, 32'h0, 0);
    check_eq("t6_no_req", 32'(o_iren), 32'd0);

    // Random traffic over a small address pool so hits and conflicts recur.
    for (int i = 0; i < 8; i++) begin
      pool[i] = {$urandom_range(3, 0) == 0 ? 24'h0 : 24'(($urandom % 4) + 1), 8'h0}
              | (32'($urandom_range(3, 0)) << 2);
    end
    for (int n = 0; n < 600; n++) begin
      a = pool[$urandom_range(7, 0)] | 32'($urandom_range(3, 0));
      cycle($urandom_range(9, 0) < 8, a, $urandom_range(9, 0) < 4,
            $urandom, $urandom_range(99, 0) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
